// File: rtl/tlb_assoc.sv
// Set-associative TLB with a fully-associative superpage array, shared by fetch and LSU.
// One-cycle lookup after acceptance, PTW refill on miss, SFENCE via per-set sweep.
module tlb_assoc #(
  parameter int WAYS       = 2,
  parameter int DEPTH      = 32,
  parameter int SP_ENTRIES = 4,
  parameter int ASIDLEN    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               translation_on,
  input  logic [ASIDLEN-1:0] asid,
  input  logic [1:0]         privilege,
  input  logic               mxr,
  input  logic               sum,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_vaddr,
  input  logic               req_rnw,
  input  logic               req_execute,
  output logic               resp_valid,
  output logic               resp_fault,
  output logic [31:0]        resp_paddr,
  output logic               mmu_req,
  output logic [31:0]        mmu_vaddr,
  output logic               mmu_rnw,
  output logic               mmu_execute,
  input  logic               mmu_fill,
  input  logic               mmu_fault,
  input  logic               mmu_superpage,
  input  logic [19:0]        mmu_ppn,
  input  logic [5:0]         mmu_perms,
  input  logic               sfence_valid,
  input  logic               sfence_addr_only,
  input  logic               sfence_asid_only,
  input  logic [31:0]        sfence_addr,
  input  logic [ASIDLEN-1:0] sfence_asid,
  output logic               sfence_done
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = 20 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SP_W  = (SP_ENTRIES > 1) ? $clog2(SP_ENTRIES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_FLUSH} state_t;

  // perms layout {d,g,u,x,w,r}
  function automatic logic perm_ok(input logic [5:0] p, input logic rnw, input logic exe,
                                   input logic [1:0] priv, input logic f_mxr, input logic f_sum);
    logic acc, mode;
    if (exe)      acc = p[2];
    else if (rnw) acc = p[0] | (p[2] & f_mxr);
    else          acc = p[1] & p[5];
    case (priv)
      2'd0:    mode = p[3];
      2'd1:    mode = ~p[3] | (f_sum & ~exe);
      default: mode = 1'b1;
    endcase
    return acc & mode;
  endfunction

  function automatic logic flush_hit(input logic ao, input logic so, input logic tag_eq,
                                     input logic g, input logic asid_eq);
    return (~ao | tag_eq) & (~so | (~g & asid_eq));
  endfunction

  state_t                r_state;
  logic [DEPTH-1:0]      r_valid   [WAYS];
  logic [ASIDLEN-1:0]    r_asid    [WAYS][DEPTH];
  logic [TAG_W-1:0]      r_tag     [WAYS][DEPTH];
  logic [19:0]           r_ppn     [WAYS][DEPTH];
  logic [5:0]            r_perm    [WAYS][DEPTH];
  logic [WAY_W-1:0]      r_rr      [DEPTH];
  logic [SP_ENTRIES-1:0] r_sp_valid;
  logic [ASIDLEN-1:0]    r_sp_asid [SP_ENTRIES];
  logic [9:0]            r_sp_tag  [SP_ENTRIES];
  logic [9:0]            r_sp_ppn  [SP_ENTRIES];
  logic [5:0]            r_sp_perm [SP_ENTRIES];
  logic [SP_W-1:0]       r_sp_rr;
  logic [31:0]           r_vaddr;
  logic                  r_rnw, r_exec;
  logic                  r_sf_ao, r_sf_so, r_fl_first;
  logic [TAG_W-1:0]      r_sf_tag;
  logic [ASIDLEN-1:0]    r_sf_asid;
  logic [IDX_W-1:0]      r_fl_idx;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_reg_hit, w_sp_hit, w_any_hit, w_free, w_sp_free;
  logic [19:0]           w_reg_ppn;
  logic [9:0]            w_sp_ppn;
  logic [5:0]            w_reg_perm, w_sp_perm, w_perm;
  logic [WAY_W-1:0]      w_free_way, w_victim;
  logic [SP_W-1:0]       w_sp_free_idx, w_sp_victim;
  logic [WAYS-1:0]       w_fl_inv;
  logic [SP_ENTRIES-1:0] w_sp_inv;
  logic                  w_fl_last, w_lk, w_ms, w_lk_miss, w_perm_ok, w_fill;
  logic [31:0]           w_hit_pa, w_fill_pa, w_pa;
  logic                  w_unused;

  assign w_idx    = r_vaddr[12 +: IDX_W];
  assign w_tag    = r_vaddr[31 -: TAG_W];
  assign w_unused = ^sfence_addr[11:0];

  // Descending scans leave the lowest matching index selected.
  always_comb begin
    w_reg_hit = 1'b0; w_reg_ppn = '0; w_reg_perm = '0; w_free = 1'b0; w_free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[i][w_idx] && r_tag[i][w_idx] == w_tag &&
          (r_asid[i][w_idx] == asid || r_perm[i][w_idx][4])) begin
        w_reg_hit  = 1'b1;
        w_reg_ppn  = r_ppn[i][w_idx];
        w_reg_perm = r_perm[i][w_idx];
      end
      if (!r_valid[i][w_idx]) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(i);
      end
    end
  end

  always_comb begin
    w_sp_hit = 1'b0; w_sp_ppn = '0; w_sp_perm = '0; w_sp_free = 1'b0; w_sp_free_idx = '0;
    for (int i = SP_ENTRIES - 1; i >= 0; i--) begin
      if (r_sp_valid[i] && r_sp_tag[i] == r_vaddr[31:22] &&
          (r_sp_asid[i] == asid || r_sp_perm[i][4])) begin
        w_sp_hit  = 1'b1;
        w_sp_ppn  = r_sp_ppn[i];
        w_sp_perm = r_sp_perm[i];
      end
      if (!r_sp_valid[i]) begin
        w_sp_free     = 1'b1;
        w_sp_free_idx = SP_W'(i);
      end
    end
  end

  always_comb begin
    w_fl_inv = '0;
    w_sp_inv = '0;
    for (int i = 0; i < WAYS; i++)
      w_fl_inv[i] = flush_hit(r_sf_ao, r_sf_so, r_tag[i][r_fl_idx] == r_sf_tag,
                              r_perm[i][r_fl_idx][4], r_asid[i][r_fl_idx] == r_sf_asid);
    for (int i = 0; i < SP_ENTRIES; i++)
      w_sp_inv[i] = flush_hit(r_sf_ao, r_sf_so, r_sp_tag[i] == r_sf_tag[TAG_W-1 -: 10],
                              r_sp_perm[i][4], r_sp_asid[i] == r_sf_asid);
  end

  assign w_victim    = w_free ? w_free_way : r_rr[w_idx];
  assign w_sp_victim = w_sp_free ? w_sp_free_idx : r_sp_rr;
  assign w_fl_last   = r_sf_ao | (r_fl_idx == IDX_W'(DEPTH - 1));
  assign w_any_hit   = w_reg_hit | w_sp_hit;
  assign w_perm      = w_sp_hit ? w_sp_perm : w_reg_perm;
  assign w_perm_ok   = perm_ok(w_perm, r_rnw, r_exec, privilege, mxr, sum);
  assign w_hit_pa    = w_sp_hit ? {w_sp_ppn, r_vaddr[21:0]} : {w_reg_ppn, r_vaddr[11:0]};
  assign w_fill_pa   = mmu_superpage ? {mmu_ppn[19:10], r_vaddr[21:0]} : {mmu_ppn, r_vaddr[11:0]};
  assign w_lk        = (r_state == S_LOOKUP);
  assign w_ms        = (r_state == S_MISS);
  assign w_lk_miss   = w_lk & translation_on & ~w_any_hit;
  assign w_fill      = w_ms & mmu_fill & ~mmu_fault;
  assign w_pa        = w_ms ? w_fill_pa : (translation_on ? w_hit_pa : r_vaddr);

  assign req_ready   = (r_state == S_IDLE) & ~sfence_valid;
  assign mmu_req     = w_lk_miss | w_ms;
  assign mmu_vaddr   = mmu_req ? r_vaddr : 32'd0;
  assign mmu_rnw     = mmu_req & r_rnw;
  assign mmu_execute = mmu_req & r_exec;
  assign resp_valid  = (w_lk & ~w_lk_miss) | (w_ms & (mmu_fill | mmu_fault));
  assign resp_fault  = (w_lk & translation_on & w_any_hit & ~w_perm_ok) | (w_ms & mmu_fault);
  assign resp_paddr  = (resp_valid & ~resp_fault) ? w_pa : 32'd0;
  assign sfence_done = (r_state == S_FLUSH) & w_fl_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fl_idx   <= '0;
      r_fl_first <= 1'b0;
      r_sp_valid <= '0;
      r_sp_rr    <= '0;
      for (int i = 0; i < WAYS; i++) r_valid[i] <= '0;
      for (int s = 0; s < DEPTH; s++) r_rr[s] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sfence_valid) begin
            r_state    <= S_FLUSH;
            r_fl_first <= 1'b1;
            r_fl_idx   <= sfence_addr_only ? sfence_addr[12 +: IDX_W] : '0;
          end else if (req_valid) begin
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: r_state <= w_lk_miss ? S_MISS : S_IDLE;
        S_MISS: begin
          if (mmu_fault || mmu_fill) r_state <= S_IDLE;
          if (w_fill && mmu_superpage) begin
            r_sp_valid[w_sp_victim] <= 1'b1;
            if (!w_sp_free)
              r_sp_rr <= (r_sp_rr == SP_W'(SP_ENTRIES - 1)) ? '0 : r_sp_rr + SP_W'(1);
          end else if (w_fill) begin
            r_valid[w_victim][w_idx] <= 1'b1;
            if (!w_free)
              r_rr[w_idx] <= (r_rr[w_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_idx] + WAY_W'(1);
          end
        end
        S_FLUSH: begin
          for (int i = 0; i < WAYS; i++)
            if (w_fl_inv[i]) r_valid[i][r_fl_idx] <= 1'b0;
          if (r_fl_first)
            for (int i = 0; i < SP_ENTRIES; i++)
              if (w_sp_inv[i]) r_sp_valid[i] <= 1'b0;
          r_fl_first <= 1'b0;
          r_fl_idx   <= r_fl_idx + IDX_W'(1);
          if (w_fl_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Entry payloads and captured request/flush operands carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req_ready && req_valid) begin
      r_vaddr <= req_vaddr;
      r_rnw   <= req_rnw;
      r_exec  <= req_execute;
    end
    if (r_state == S_IDLE && sfence_valid) begin
      r_sf_ao   <= sfence_addr_only;
      r_sf_so   <= sfence_asid_only;
      r_sf_tag  <= sfence_addr[31 -: TAG_W];
      r_sf_asid <= sfence_asid;
    end
    if (w_fill && mmu_superpage) begin
      r_sp_asid[w_sp_victim] <= asid;
      r_sp_tag[w_sp_victim]  <= r_vaddr[31:22];
      r_sp_ppn[w_sp_victim]  <= mmu_ppn[19:10];
      r_sp_perm[w_sp_victim] <= mmu_perms;
    end else if (w_fill) begin
      r_asid[w_victim][w_idx] <= asid;
      r_tag[w_victim][w_idx]  <= w_tag;
      r_ppn[w_victim][w_idx]  <= mmu_ppn;
      r_perm[w_victim][w_idx] <= mmu_perms;
    end
  end
endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: expected responses queued at request time, compared on resp_valid.
module tb_tlb_assoc;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        translation_on;
  logic [8:0]  asid;
  logic [1:0]  privilege;
  logic        mxr, sum;
  logic        req_valid, req_ready, req_rnw, req_execute;
  logic [31:0] req_vaddr;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_paddr;
  logic        mmu_req, mmu_rnw, mmu_execute;
  logic [31:0] mmu_vaddr;
  logic        mmu_fill, mmu_fault, mmu_superpage;
  logic [19:0] mmu_ppn;
  logic [5:0]  mmu_perms;
  logic        sfence_valid, sfence_addr_only, sfence_asid_only, sfence_done;
  logic [31:0] sfence_addr;
  logic [8:0]  sfence_asid;

  always #5 clk = ~clk;

  tlb_assoc #(.WAYS(2), .DEPTH(DEPTH), .SP_ENTRIES(4), .ASIDLEN(9)) dut (
    .clk(clk), .rst_n(rst_n), .translation_on(translation_on), .asid(asid),
    .privilege(privilege), .mxr(mxr), .sum(sum),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_rnw(req_rnw), .req_execute(req_execute),
    .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_paddr(resp_paddr),
    .mmu_req(mmu_req), .mmu_vaddr(mmu_vaddr), .mmu_rnw(mmu_rnw), .mmu_execute(mmu_execute),
    .mmu_fill(mmu_fill), .mmu_fault(mmu_fault), .mmu_superpage(mmu_superpage),
    .mmu_ppn(mmu_ppn), .mmu_perms(mmu_perms),
    .sfence_valid(sfence_valid), .sfence_addr_only(sfence_addr_only),
    .sfence_asid_only(sfence_asid_only), .sfence_addr(sfence_addr),
    .sfence_asid(sfence_asid), .sfence_done(sfence_done)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] sb_q [$];
  logic [32:0] sb_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected entry: {fault, paddr}; paddr compared only for non-faulting responses.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_resp", 1, 0);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_fault", resp_fault, sb_e[32]);
        if (!sb_e[32]) check("sb_paddr", resp_paddr, sb_e[31:0]);
      end
    end
  end

  task automatic lookup(input logic [31:0] va, input logic rnw, input logic exe,
                        input logic miss, input logic pte_fault, input logic sp,
                        input logic [19:0] ppn, input logic [5:0] perms,
                        input logic exp_fault, input logic [31:0] exp_pa);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_vaddr = va; req_rnw = rnw; req_execute = exe;
    sb_q.push_back({exp_fault, exp_pa});
    tick();
    req_valid = 1'b0;
    check("mmu_req_n1", mmu_req, miss);
    if (miss) begin
      check("mmu_vaddr", mmu_vaddr, va);
      check("mmu_rnw", mmu_rnw, rnw);
      tick();
      check("mmu_req_hold", mmu_req, 1);
      check("mmu_vaddr_hold", mmu_vaddr, va);
      check("resp_quiet_miss", resp_valid, 0);
      mmu_fill = ~pte_fault; mmu_fault = pte_fault; mmu_superpage = sp;
      mmu_ppn = ppn; mmu_perms = perms;
      #1;
      check("resp_on_walk_done", resp_valid, 1);
      tick();
      mmu_fill = 1'b0; mmu_fault = 1'b0;
    end else begin
      check("resp_n1", resp_valid, 1);
      tick();
    end
    check("req_ready_back", req_ready, 1);
    check("resp_pulse_end", resp_valid, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic sfence(input logic ao, input logic so, input logic [31:0] a,
                        input logic [8:0] as, input int exp_cyc);
    int cnt;
    sfence_valid = 1'b1; sfence_addr_only = ao; sfence_asid_only = so;
    sfence_addr = a; sfence_asid = as;
    #1;
    check("sf_blocks_req", req_ready, 0);
    tick();
    sfence_valid = 1'b0;
    cnt = 1;
    while (!sfence_done && cnt < 4 * DEPTH) begin
      check("sf_busy_ready", req_ready, 0);
      tick();
      cnt++;
    end
    check("sf_cycles", cnt, exp_cyc);
    tick();
    check("sf_done_pulse", sfence_done, 0);
    check("sf_ready_back", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; translation_on = 1'b1; asid = 9'd1; privilege = 2'd1; mxr = 1'b0; sum = 1'b0;
    req_valid = 1'b0; req_vaddr = '0; req_rnw = 1'b1; req_execute = 1'b0;
    mmu_fill = 1'b0; mmu_fault = 1'b0; mmu_superpage = 1'b0; mmu_ppn = '0; mmu_perms = '0;
    sfence_valid = 1'b0; sfence_addr_only = 1'b0; sfence_asid_only = 1'b0;
    sfence_addr = '0; sfence_asid = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_fault", resp_fault, 0);
    check("rst_resp_paddr", resp_paddr, 0);
    check("rst_mmu_req", mmu_req, 0);
    check("rst_mmu_vaddr", mmu_vaddr, 0);
    check("rst_mmu_rnw_exec", {mmu_rnw, mmu_execute}, 0);
    check("rst_sfence_done", sfence_done, 0);

    // Regular miss, fill, then hit
    lookup(32'h0040_1234, 1, 0, 1, 0, 0, 20'h12345, 6'b100001, 0, 32'h1234_5234);
    lookup(32'h0040_1234, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h1234_5234);
    // Superpage fill then hit at the far end of the 4 MiB page
    lookup(32'h8040_0000, 1, 0, 1, 0, 1, 20'hFFC00, 6'b100001, 0, 32'hFFC0_0000);
    lookup(32'h807F_FFFC, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'hFFFF_FFFC);
    // Three tags into set 3: third evicts way 0
    lookup(32'h0000_3000, 1, 0, 1, 0, 0, 20'h00A00, 6'b100001, 0, 32'h00A0_0000);
    lookup(32'h0010_3000, 1, 0, 1, 0, 0, 20'h00B00, 6'b100001, 0, 32'h00B0_0000);
    lookup(32'h0020_3000, 1, 0, 1, 0, 0, 20'h00C00, 6'b100001, 0, 32'h00C0_0000);
    lookup(32'h0000_3000, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);
    lookup(32'h0010_3ABC, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h00B0_0ABC);
    lookup(32'h0020_3004, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h00C0_0004);
    // Permissions: w=1,d=0 write; x=0 fetch; U-mode on u=0
    lookup(32'h0100_5000, 1, 0, 1, 0, 0, 20'h00D00, 6'b000011, 0, 32'h00D0_0000);
    lookup(32'h0100_5010, 0, 0, 0, 0, 0, 20'h0, 6'b0, 1, 32'h0);
    lookup(32'h0100_5010, 1, 1, 0, 0, 0, 20'h0, 6'b0, 1, 32'h0);
    privilege = 2'd0;
    lookup(32'h0100_5010, 1, 0, 0, 0, 0, 20'h0, 6'b0, 1, 32'h0);
    privilege = 2'd1;
    lookup(32'h0200_6000, 1, 0, 1, 0, 0, 20'h00E00, 6'b101001, 0, 32'h00E0_0000);
    lookup(32'h0200_6020, 1, 0, 0, 0, 0, 20'h0, 6'b0, 1, 32'h0);
    sum = 1'b1;
    lookup(32'h0200_6020, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h00E0_0020);
    sum = 1'b0;
    // Execute-only page: readable only with mxr
    lookup(32'h0300_7000, 1, 1, 1, 0, 0, 20'h00F00, 6'b000100, 0, 32'h00F0_0000);
    lookup(32'h0300_7040, 1, 0, 0, 0, 0, 20'h0, 6'b0, 1, 32'h0);
    mxr = 1'b1;
    lookup(32'h0300_7040, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h00F0_0040);
    mxr = 1'b0;
    lookup(32'h0300_7044, 1, 1, 0, 0, 0, 20'h0, 6'b0, 0, 32'h00F0_0044);

    // Global vs ASID-5 entries, then ASID-only flush
    asid = 9'd5;
    lookup(32'h0400_8000, 1, 0, 1, 0, 0, 20'h00601, 6'b110001, 0, 32'h0060_1000);
    lookup(32'h0500_9000, 1, 0, 1, 0, 0, 20'h00602, 6'b100001, 0, 32'h0060_2000);
    asid = 9'd6;
    lookup(32'h0500_9000, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);
    lookup(32'h0400_8008, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h0060_1008);
    asid = 9'd5;
    lookup(32'h0500_9008, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h0060_2008);
    sfence(0, 1, 32'h0, 9'd5, DEPTH);
    lookup(32'h0400_8010, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h0060_1010);
    lookup(32'h0500_9010, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);

    // Full flush clears everything, superpages included
    sfence(0, 0, 32'h0, 9'd0, DEPTH);
    lookup(32'h0040_1234, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);
    lookup(32'h0400_8010, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);
    lookup(32'h807F_FFFC, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);

    // Address-only flush removes only the matching tag in set 1
    lookup(32'h0040_1234, 1, 0, 1, 0, 0, 20'h12345, 6'b100001, 0, 32'h1234_5234);
    lookup(32'h0050_1000, 1, 0, 1, 0, 0, 20'h00777, 6'b100001, 0, 32'h0077_7000);
    sfence(1, 0, 32'h0040_1000, 9'd0, 1);
    lookup(32'h0040_1234, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);
    lookup(32'h0050_1FF0, 1, 0, 0, 0, 0, 20'h0, 6'b0, 0, 32'h0077_7FF0);

    // Simultaneous sfence and request: flush first, request held until accepted
    translation_on = 1'b0;
    req_valid = 1'b1; req_vaddr = 32'h1357_9BDF; req_rnw = 1'b1; req_execute = 1'b0;
    sfence(0, 0, 32'h0, 9'd0, DEPTH);
    sb_q.push_back({1'b0, 32'h1357_9BDF});
    tick();
    req_valid = 1'b0;
    check("held_req_resp", resp_valid, 1);
    tick();
    check("held_req_drained", sb_q.size(), 0);
    translation_on = 1'b1;

    // Reset mid-walk abandons the walk; a late fill is ignored
    lookup(32'h0050_1000, 1, 0, 1, 0, 0, 20'h00777, 6'b100001, 0, 32'h0077_7000);
    req_valid = 1'b1; req_vaddr = 32'h0600_A000; req_rnw = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_mmu_req", mmu_req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_miss_mmu_req", mmu_req, 0);
    check("rst_mid_miss_mmu_vaddr", mmu_vaddr, 0);
    check("rst_mid_miss_ready", req_ready, 1);
    tick();
    rst_n = 1'b1;
    mmu_fill = 1'b1; mmu_ppn = 20'h0ABCD; mmu_perms = 6'b100001; mmu_superpage = 1'b0;
    #1;
    check("late_fill_ignored", resp_valid, 0);
    tick();
    mmu_fill = 1'b0;
    check("post_rst_ready", req_ready, 1);
    lookup(32'h0600_A000, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);
    lookup(32'h0050_1000, 1, 0, 1, 1, 0, 20'h0, 6'b0, 1, 32'h0);

    check("sb_final_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
